// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: digit width,
// the blank pattern and the active-low hex segment table {g,f,e,d,c,b,a}.
package bcd_display_scan_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;

   // Entry n occupies bits [7n+6:7n]; listed from F down to 0.
   localparam logic [16*7-1:0] SEG_TABLE = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

   function automatic seg_t hexSeg(input logic [DIGIT_W-1:0] hex);
      return SEG_TABLE[7*hex +: 7];
   endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Display bus: load/value/blanking request from the BCD stage, segment and
// enable drive toward the panel.
interface bcd_display_scan_if #(
   parameter int N_DIGITS = 4
);
   logic                  load;
   logic [4*N_DIGITS-1:0] bcd_in;
   logic                  blank_lz;
   logic [6:0]            seg;
   logic [N_DIGITS-1:0]   dig_en;
   logic                  pending;

   modport master (output load, output bcd_in, output blank_lz,
                   input seg, input dig_en, input pending);
   modport slave  (input load, input bcd_in, input blank_lz,
                   output seg, output dig_en, output pending);
endinterface

// File: rtl/bcd_display_scan_hex_to_7seg.sv
// Existing hex digit to active-low 7-segment decoder (A-F shown as hex).
module hex_to_7seg
   import bcd_display_scan_pkg::*;
(
   input  logic [DIGIT_W-1:0] hex_i,
   output seg_t               seg_o
);

   assign seg_o = hexSeg(hex_i);

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver with double-buffered digits, leading-zero
// blanking and a per-slot ghost-suppression gap; outputs are registered.
module bcd_display_scan
   import bcd_display_scan_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int PRESCALE = 50000,
   parameter int GUARD    = 16
) (
   input  logic               clk,
   input  logic               rst,
   bcd_display_scan_if.slave  bus
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int W  = DIGIT_W * N_DIGITS;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [W-1:0]        shd_q, shd_d;
   logic [W-1:0]        pend_q, pend_d;
   logic                pendValid_q, pendValid_d;
   seg_t                seg_q, seg_d;
   logic [N_DIGITS-1:0] digEn_q, digEn_d;

   logic                tc;
   logic                fb;
   logic [DIGIT_W-1:0]  curDigit;
   seg_t                decSeg;
   logic [N_DIGITS-1:0] lzBlank;
   logic                zeroAbove;

   assign tc       = (cnt_q == CW'(PRESCALE - 1));
   assign fb       = tc && (idx_q == IW'(N_DIGITS - 1));
   assign curDigit = shd_q[DIGIT_W*idx_q +: DIGIT_W];

   hex_to_7seg uDecoder (
      .hex_i (curDigit),
      .seg_o (decSeg)
   );

   // A digit is a leading zero when it and every digit above it are zero;
   // digit 0 is never part of the mask so a zero value still shows "0".
   always_comb begin
      zeroAbove = 1'b1;
      lzBlank   = '0;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zeroAbove  = zeroAbove && (shd_q[DIGIT_W*i +: DIGIT_W] == '0);
         lzBlank[i] = zeroAbove;
      end
   end

   always_comb begin
      cnt_d       = tc ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      shd_d       = shd_q;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      if (tc) begin
         idx_d = fb ? '0 : idx_q + 1'b1;
      end

      // A load landing on the frame boundary bypasses the pending buffer.
      if (bus.load && fb) begin
         shd_d       = bus.bcd_in;
         pendValid_d = 1'b0;
      end else if (bus.load) begin
         pend_d      = bus.bcd_in;
         pendValid_d = 1'b1;
      end else if (fb && pendValid_q) begin
         shd_d       = pend_q;
         pendValid_d = 1'b0;
      end

      if (cnt_q < CW'(GUARD)) begin
         seg_d   = SEG_BLANK;
         digEn_d = '1;
      end else begin
         seg_d   = (bus.blank_lz && lzBlank[idx_q]) ? SEG_BLANK : decSeg;
         digEn_d = ~(N_DIGITS'(1) << idx_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         shd_q       <= '0;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
         seg_q       <= SEG_BLANK;
         digEn_q     <= '1;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shd_q       <= shd_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
         seg_q       <= seg_d;
         digEn_q     <= digEn_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.dig_en  = digEn_q;
   assign bus.pending = pendValid_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Cycle-by-cycle check of bcd_display_scan against a time-arithmetic model
// using directed scenarios followed by randomized loads and blanking.
module tb_bcd_display_scan;

   localparam int N = 4;
   localparam int P = 4;
   localparam int G = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bcd_display_scan_if #(.N_DIGITS(N)) bus ();

   bcd_display_scan #(.N_DIGITS(N), .PRESCALE(P), .GUARD(G)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checksDone   = 0;
   int checksPassed = 0;

   logic [6:0] segRef [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Model: time since reset plus the displayed / waiting values.
   int          t;
   logic [15:0] mShd;
   logic [15:0] mPend;
   logic        mValid;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checksDone++;
      if (observed === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h, expected %h (t=%0d)", tag, observed, expected, t);
   endtask

   task automatic modelReset();
      t      = 0;
      mShd   = '0;
      mPend  = '0;
      mValid = 1'b0;
   endtask

   // Drive one cycle of inputs, predict the registered outputs and check them.
   task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic blz);
      int          cnt;
      int          idx;
      logic [15:0] upper;
      logic [6:0]  expSeg;
      logic [3:0]  expEn;
      logic        fbNow;
      bus.load     = ld;
      bus.bcd_in   = val;
      bus.blank_lz = blz;
      cnt = t % P;
      idx = (t / P) % N;
      if (cnt < G) begin
         expSeg = 7'b1111111;
         expEn  = 4'b1111;
      end else begin
         upper  = mShd >> (4 * idx);
         expEn  = ~(4'b0001 << idx);
         expSeg = (blz && idx != 0 && upper == 16'h0) ? 7'b1111111 : segRef[upper[3:0]];
      end
      fbNow = (cnt == P - 1) && (idx == N - 1);
      if (ld && fbNow) begin
         mShd   = val;
         mValid = 1'b0;
      end else if (ld) begin
         mPend  = val;
         mValid = 1'b1;
      end else if (fbNow && mValid) begin
         mShd   = mPend;
         mValid = 1'b0;
      end
      t++;
      @(posedge clk);
      #1;
      checkOutput("seg", {9'b0, bus.seg}, {9'b0, expSeg});
      checkOutput("dig_en", {12'b0, bus.dig_en}, {12'b0, expEn});
      checkOutput("pending", {15'b0, bus.pending}, {15'b0, mValid});
   endtask

   task automatic idleUntil(input int tCnt, input int tIdx, input logic blz);
      int budget;
      budget = 0;
      while (((t % P) != tCnt || ((t / P) % N) != tIdx) && budget < 64) begin
         applyStimulus(1'b0, 16'h0, blz);
         budget++;
      end
      if (budget >= 64) begin
         checksDone++;
         $display("[TB] FAIL idleUntil: slot cnt=%0d idx=%0d not reached", tCnt, tIdx);
      end
   endtask

   task automatic runCycles(input int n, input logic blz);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, blz);
   endtask

   task automatic midSlotReset();
      #2;
      rst = 1'b1;
      bus.load = 1'b0;
      #1;
      checkOutput("rst_seg", {9'b0, bus.seg}, 16'h007F);
      checkOutput("rst_dig_en", {12'b0, bus.dig_en}, 16'h000F);
      checkOutput("rst_pending", {15'b0, bus.pending}, 16'h0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      modelReset();
   endtask

   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.bcd_in   = '0;
      bus.blank_lz = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("init_seg", {9'b0, bus.seg}, 16'h007F);
      checkOutput("init_dig_en", {12'b0, bus.dig_en}, 16'h000F);
      checkOutput("init_pending", {15'b0, bus.pending}, 16'h0000);
      rst = 1'b0;

      $display("[TB] reset mid-slot with a load pending");
      runCycles(3, 1'b0);
      applyStimulus(1'b1, 16'hABCD, 1'b0);
      idleUntil(3, 1, 1'b0);
      midSlotReset();
      runCycles(2 * N * P, 1'b0);

      $display("[TB] basic scan 1234");
      applyStimulus(1'b1, 16'h1234, 1'b0);
      runCycles(2 * N * P, 1'b0);

      $display("[TB] blanking 0050");
      applyStimulus(1'b1, 16'h0050, 1'b1);
      runCycles(2 * N * P, 1'b1);
      runCycles(N * P, 1'b0);

      $display("[TB] zero value");
      applyStimulus(1'b1, 16'h0000, 1'b1);
      runCycles(2 * N * P, 1'b1);

      $display("[TB] double buffer 1111 then 2222");
      idleUntil(1, 1, 1'b0);
      applyStimulus(1'b1, 16'h1111, 1'b0);
      idleUntil(1, 2, 1'b0);
      applyStimulus(1'b1, 16'h2222, 1'b0);
      runCycles(2 * N * P, 1'b0);

      $display("[TB] collision 9999 on frame boundary");
      idleUntil(1, 1, 1'b0);
      applyStimulus(1'b1, 16'h5555, 1'b0);
      idleUntil(P - 1, N - 1, 1'b0);
      applyStimulus(1'b1, 16'h9999, 1'b0);
      runCycles(2 * N * P, 1'b0);

      $display("[TB] randomized loads and blanking");
      for (int i = 0; i < 400; i++) begin
         logic        ld;
         logic [15:0] val;
         ld  = ($urandom_range(0, 7) == 0);
         val = 16'($urandom);
         if ($urandom_range(0, 1) == 1) val[15:8] = 8'h00;
         applyStimulus(ld, val, 1'($urandom_range(0, 1)));
      end
      idleUntil(2, 2, 1'b1);
      midSlotReset();
      runCycles(N * P, 1'b1);

      $display("%0d/%0d checks passed", checksPassed, checksDone);
      $finish;
   end

endmodule
